// File: rtl/serial_inv_beta.sv
// Inverse SWAN64 beta layer: applies the inverse 4-bit S-box to each bit-sliced
// column of a 32-bit half-state, LANES columns per clock, behind valid/ready.
module serial_inv_beta #(
  parameter int BLOCK_SIZE  = 64,
  parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
  parameter int COLUMN_SIZE = SIDE_SIZE / 4,
  parameter int SBOX_SIZE   = 4,
  parameter int LANES       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:SIDE_SIZE-1] x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:SIDE_SIZE-1] y,
  output logic                 busy
);

  localparam int CNT_W = $clog2(COLUMN_SIZE) + 1;
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] COLS_C  = CNT_W'(COLUMN_SIZE);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("serial_inv_beta: LANES must be 1, 2, 4 or 8");
  end
  if (SBOX_SIZE != 4) begin : g_bad_sbox
    $error("serial_inv_beta: only a 4-bit S-box is supported");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [0:SIDE_SIZE-1]   res_q, res_d;
  logic                   out_valid_q, out_valid_d;

  // Inverse of the PRESENT-style S-box C56B90AD3EF84712.
  function automatic logic [3:0] inv_sbox(input logic [3:0] v);
    logic [3:0] r;
    case (v)
      4'h0: r = 4'h5;  4'h1: r = 4'hE;  4'h2: r = 4'hF;  4'h3: r = 4'h8;
      4'h4: r = 4'hC;  4'h5: r = 4'h1;  4'h6: r = 4'h2;  4'h7: r = 4'hD;
      4'h8: r = 4'hB;  4'h9: r = 4'h4;  4'hA: r = 4'h6;  4'hB: r = 4'h3;
      4'hC: r = 4'h0;  4'hD: r = 4'h7;  4'hE: r = 4'h9;  default: r = 4'hA;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          res_d   = x;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Column c occupies bits c, c+8, c+16, c+24 with bit c as the MSB.
        for (int l = 0; l < LANES; l++) begin
          int         col;
          logic [3:0] nib;
          col = (int'(cnt_q) + l) % COLUMN_SIZE;
          nib = {res_q[col], res_q[col + COLUMN_SIZE],
                 res_q[col + 2*COLUMN_SIZE], res_q[col + 3*COLUMN_SIZE]};
          nib = inv_sbox(nib);
          res_d[col]                 = nib[3];
          res_d[col + COLUMN_SIZE]   = nib[2];
          res_d[col + 2*COLUMN_SIZE] = nib[1];
          res_d[col + 3*COLUMN_SIZE] = nib[0];
        end
        if (cnt_q + LANES_C == COLS_C) begin
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + LANES_C;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign y         = res_q;

endmodule

// File: tb/tb_serial_inv_beta.sv
// Bench for serial_inv_beta: four instances (LANES 1,2,4,8) checked by round trip
// through a forward beta model: inv_beta(beta(y0)) must return y0.
module tb_serial_inv_beta;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [0:31] x         [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [0:31] y         [4];
  logic        busy      [4];

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  serial_inv_beta #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .x(x[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .y(y[0]), .busy(busy[0]));
  serial_inv_beta #(.LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .x(x[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .y(y[1]), .busy(busy[1]));
  serial_inv_beta #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .x(x[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .y(y[2]), .busy(busy[2]));
  serial_inv_beta #(.LANES(8)) u_l8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .x(x[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .y(y[3]), .busy(busy[3]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // forward S-box; the DUT must undo it
  function automatic logic [3:0] sbox(input logic [3:0] v);
    logic [3:0] r;
    case (v)
      4'h0: r = 4'hC;  4'h1: r = 4'h5;  4'h2: r = 4'h6;  4'h3: r = 4'hB;
      4'h4: r = 4'h9;  4'h5: r = 4'h0;  4'h6: r = 4'hA;  4'h7: r = 4'hD;
      4'h8: r = 4'h3;  4'h9: r = 4'hE;  4'hA: r = 4'hF;  4'hB: r = 4'h8;
      4'hC: r = 4'h4;  4'hD: r = 4'h7;  4'hE: r = 4'h1;  default: r = 4'h2;
    endcase
    return r;
  endfunction

  function automatic logic [0:31] serial_beta(input logic [0:31] v);
    logic [0:31] r;
    logic [3:0]  n;
    r = v;
    for (int c = 0; c < 8; c++) begin
      n = sbox({v[c], v[c+8], v[c+16], v[c+24]});
      r[c] = n[3]; r[c+8] = n[2]; r[c+16] = n[1]; r[c+24] = n[0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // driver: one operation on instance k, checking latency n and result ey
  task automatic run_op(input int k, input logic [31:0] y0, input int n, input string tag);
    int cnt;
    @(negedge clk);
    in_valid[k] = 1'b1;
    x[k]        = serial_beta(y0);
    @(negedge clk);
    in_valid[k] = 1'b0;
    cnt = 0;
    while (!out_valid[k] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'(n));
    chk({tag, "_y"}, y[k], y0);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    chk({tag, "_idle"}, {30'd0, out_valid[k], in_ready[k]}, 32'd1);
  endtask

  initial begin
    logic [31:0] hold_y;
    logic [31:0] y0;
    logic [3:0]  vv;
    int lanes_n[4];
    int sent, recv, cyc;
    checks = 0;
    errors = 0;
    lanes_n[0] = 8; lanes_n[1] = 4; lanes_n[2] = 2; lanes_n[3] = 1;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; x[k] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++)
      chk("reset_state", {y[k], 28'd0, out_valid[k], in_ready[k], busy[k], 1'b0}, 64'h0000_0000_0000_0004 >> 0);

    // 1. reset during RUN (third RUN edge) discards the operation
    in_valid[0] = 1'b1;
    x[0] = serial_beta(32'hDEADBEEF);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_run_y", y[0], 32'h0);
    chk("rst_run_flags", {29'd0, out_valid[0], in_ready[0], busy[0]}, 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_run_flags2", {29'd0, out_valid[0], in_ready[0], busy[0]}, 32'h2);
    run_op(0, 32'hCAFEF00D, 8, "after_reset");

    // 2. round trip with LANES=1 and LANES=8
    run_op(0, 32'h01234567, 8, "rt_l1");
    run_op(3, 32'h01234567, 1, "rt_l8");

    // 3. every nibble value in every column, all lane counts
    for (int k = 0; k < 4; k++) begin
      for (int v = 0; v < 16; v++) begin
        vv = 4'(v);
        y0 = {{8{vv[3]}}, {8{vv[2]}}, {8{vv[1]}}, {8{vv[0]}}};
        run_op(k, y0, lanes_n[k], $sformatf("nib_k%0d_v%0d", k, v));
      end
    end

    // 4. backpressure in DONE with a competing in_valid
    @(negedge clk);
    in_valid[0] = 1'b1;
    x[0] = serial_beta(32'h13572468);
    @(negedge clk);
    x[0] = serial_beta(32'hA5A5F00F);
    cyc = 0;
    while (!out_valid[0] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_latency", 32'(cyc), 32'd8);
    hold_y = y[0];
    chk("bp_first_y", hold_y, 32'h13572468);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_y", y[0], hold_y);
      chk("bp_hold_flags", {29'd0, out_valid[0], in_ready[0], busy[0]}, 32'h5);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk("bp_release", {29'd0, out_valid[0], in_ready[0], busy[0]}, 32'h2);
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("bp_second_taken", {29'd0, out_valid[0], in_ready[0], busy[0]}, 32'h1);
    cyc = 0;
    while (!out_valid[0] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_second_y", y[0], 32'hA5A5F00F);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;

    // 5. random streaming, LANES=2, scoreboard keeps expected order
    sent = 0; recv = 0; cyc = 0;
    hold_y = '0;
    while (recv < 1000 && cyc < 40000) begin
      logic iv_ok, ov_now, ir_now;
      ov_now = out_valid[1];
      ir_now = in_ready[1];
      if (cyc > 0 && hold_y[0] && !ov_now) chk("stream_ov_glitch", 32'(ov_now), 32'd1);
      in_valid[1]  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_ready[1] = ($urandom_range(0, 2) != 0);
      if (in_valid[1]) begin
        y0 = $urandom;
        x[1] = serial_beta(y0);
      end
      iv_ok = in_valid[1] && ir_now;
      if (iv_ok) begin
        exp_q.push_back(y0);
        sent++;
      end
      if (ov_now && out_ready[1]) begin
        if (exp_q.size() == 0) chk("stream_extra", 32'd1, 32'd0);
        else chk("stream_y", y[1], exp_q.pop_front());
        recv++;
      end
      hold_y[0] = ov_now && !out_ready[1];
      @(negedge clk);
      cyc++;
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b0;
    chk("stream_count", 32'(recv), 32'd1000);
    chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6. three back-to-back operations on LANES=4
    run_op(2, 32'h00000000, 2, "wrap0");
    run_op(2, 32'hFFFFFFFF, 2, "wrap1");
    run_op(2, 32'h5A3C96E1, 2, "wrap2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
